dma_burst_scheduler: RTL
========================

// Module: dma_burst_scheduler
// PURPOSE
// - Command sequencer in front of the AXI DMA engine. Accepts transfer descriptors (src, dst, bytes) into a small queue.
// - Splits each descriptor into AXI4 bursts that never cross a 4 KB boundary and never exceed MAX_BEATS.
// - Issues the bursts to the DMA one at a time and reports completion or error per descriptor.
// PARAMETERS
// - ADDR_W      32   address width, bytes
// - LEN_W       20   descriptor byte-length width
// - DATA_BYTES  4    bytes per AXI beat (power of 2)
// - MAX_BEATS   256  max beats per burst (1..256)
// - DESC_DEPTH  4    descriptor FIFO depth (power of 2)
// PORTS
// - ACLK          in   1       clock
// - ARESET        in   1       asynchronous reset, active-high
// - desc_valid    in   1       descriptor offered
// - desc_ready    out  1       = !fifo_full
// - desc_src      in   ADDR_W  source byte address (DATA_BYTES-aligned)
// - desc_dst      in   ADDR_W  destination byte address (DATA_BYTES-aligned)
// - desc_bytes    in   LEN_W   byte count (multiple of DATA_BYTES)
// - cmd_valid     out  1       burst command to DMA
// - cmd_ready     in   1       DMA accepts command
// - cmd_src       out  ADDR_W  burst source address
// - cmd_dst       out  ADDR_W  burst destination address
// - cmd_len       out  8       AXI LEN (beats-1)
// - dma_done      in   1       1-cycle pulse: issued burst finished OK
// - dma_err       in   1       1-cycle pulse: issued burst failed (SLVERR/DECERR)
// - done_pulse    out  1       1-cycle pulse: descriptor retired
// - done_err      out  1       valid with done_pulse: descriptor aborted
// - busy          out  1       FSM not IDLE or FIFO non-empty
// BEHAVIOUR
// - Reset: FIFO emptied; FSM=IDLE; cmd_valid/done_pulse/done_err/busy=0; cmd_* data=0; desc_ready=1 after reset.
// - Push on desc_valid&&desc_ready. There is no bypass. A push into a full FIFO is impossible because desc_ready=0.
// - Push and pop in the same cycle are both legal. With the FIFO full, a pop does not raise desc_ready until the next cycle.
// - FSM IDLE->LOAD: when FIFO is non-empty, pop into cur_src/cur_dst/rem.
// - FSM LOAD->CALC:
//     - If rem==0: retire immediately (done_pulse=1, done_err=0) and go to IDLE.
// - FSM CALC->ISSUE: chunk = min(rem, MAX_BEATS*DATA_BYTES, 4096-cur_src[11:0], 4096-cur_dst[11:0]).
//     - Compute chunk with 13-bit boundary terms.
//     - Register cmd_len = chunk/DATA_BYTES-1.
// - FSM ISSUE: cmd_valid=1. cmd_* stays stable until cmd_ready, then go to WAIT with cmd_valid=0 the next cycle.
// - FSM WAIT:
//     - dma_done: cur_src+=chunk, cur_dst+=chunk, rem-=chunk. Go to CALC if rem!=0.
//     - If rem==0 after dma_done: done_pulse=1, done_err=0, go to IDLE.
//     - dma_err: done_pulse=1, done_err=1. Drop the remainder; go to IDLE.
//     - dma_done and dma_err in the same cycle: error wins.
//     - dma_done/dma_err outside WAIT: ignored.
// - Latency, IDLE with FIFO non-empty to first cmd_valid: 3 cycles (LOAD, CALC, ISSUE).
// - Latency, dma_done to next cmd_valid: 2 cycles.
// - Addresses wrap modulo 2^ADDR_W; this is not flagged.
// - Misaligned desc_src/dst/bytes: low log2(DATA_BYTES) bits are forced to 0 on push.
// - ARESET mid-burst: everything is cleared at once. The DMA must also be reset; no draining.
// CONFIGURATION
// - DMA_SCHED_STATS_EN defined: adds outputs stat_bursts[31:0] and stat_descs[31:0].
//     - stat_bursts +1 per cmd handshake.
//     - stat_descs +1 per done_pulse.
//     - Both wrap at 2^32 and reset to 0.
// - DMA_SCHED_STATS_EN undefined: the ports and counters are absent.
// TESTING
// - T1 single burst: src=0x1000, dst=0x2000, bytes=0x40 -> one cmd (src 0x1000, dst 0x2000, len 15); done_pulse 1 cycle after dma_done, done_err=0.
// - T2 4 KB split: src=0x0F00, dst=0x10000, bytes=0x400 -> cmd(0x0F00,0x10000,len 63), then cmd(0x1000,0x10100,len 191).
// - T3 max-burst split: src=0, dst=0x8000, bytes=0x1000 -> 4 cmds, len 255 each, src 0/0x400/0x800/0xC00.
// - T4 FIFO full and zero length:
//     - 5 pushes with cmd_ready=0 -> desc_ready=0 after 4 stored (1 popped plus 4 queued).
//     - A bytes=0 descriptor -> done_pulse with no cmd_valid.
// - T5 error: 3-burst descriptor, dma_err on burst 2 -> done_err=1, no 3rd cmd, next descriptor starts normally.
// - T6 reset mid-WAIT: ARESET asserted -> cmd_valid=0, busy=0, desc_ready=1 after release; queued descriptors lost. With DMA_SCHED_STATS_EN, T3 gives stat_bursts=4, stat_descs=1.

Source files
------------

// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler: descriptor queue that splits transfers into 4 KB-safe AXI bursts for a DMA engine
//   ACLK, ARESET               clock, asynchronous active-high reset
//   desc_*_i / desc_ready_o    descriptor push port (src, dst, byte count)
//   cmd_*_o / cmd_ready_i      burst command to the DMA (src, dst, AXI LEN)
//   dma_done_i / dma_err_i     per-burst completion pulses from the DMA
//   done_pulse_o / done_err_o  per-descriptor retirement pulse and error flag
//   busy_o                     FSM active or descriptors queued
//   DMA_SCHED_STATS_EN         when defined, adds stat_bursts_o / stat_descs_o counters
module dma_burst_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 20,
    parameter int DATA_BYTES = 4,
    parameter int MAX_BEATS  = 256,
    parameter int DESC_DEPTH = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              desc_valid_i,
    output logic              desc_ready_o,
    input  logic [ADDR_W-1:0] desc_src_i,
    input  logic [ADDR_W-1:0] desc_dst_i,
    input  logic [LEN_W-1:0]  desc_bytes_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [ADDR_W-1:0] cmd_src_o,
    output logic [ADDR_W-1:0] cmd_dst_o,
    output logic [7:0]        cmd_len_o,
    input  logic              dma_done_i,
    input  logic              dma_err_i,
    output logic              done_pulse_o,
    output logic              done_err_o,
`ifdef DMA_SCHED_STATS_EN
    output logic              busy_o,
    output logic [31:0]       stat_bursts_o,
    output logic [31:0]       stat_descs_o
`else
    output logic              busy_o
`endif
);
    localparam int AW = $clog2(DESC_DEPTH);
    localparam int SH = $clog2(DATA_BYTES);
    localparam int CW = (LEN_W > 13 ? LEN_W : 13) + 1;
    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(DATA_BYTES - 1);
    localparam logic [LEN_W-1:0]  LMASK = ~LEN_W'(DATA_BYTES - 1);
    localparam logic [CW-1:0]     MAX_BYTES = CW'(MAX_BEATS * DATA_BYTES);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, ISSUE, WAIT} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_mem [DESC_DEPTH];
    logic [ADDR_W-1:0] dst_mem [DESC_DEPTH];
    logic [LEN_W-1:0]  len_mem [DESC_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic              full, empty, push, pop;

    logic [ADDR_W-1:0] cur_src_q, cur_dst_q, cmd_src_q, cmd_dst_q;
    logic [LEN_W-1:0]  rem_q, chunk_q, rem_left;
    logic [7:0]        cmd_len_q, len_w;
    logic [12:0]       src_room, dst_room, room;
    logic [CW-1:0]     lim, chunk_w;
    logic              done_pulse_q, done_err_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = desc_valid_i && !full;

    always_ff @(posedge ACLK) begin
        if (push) begin
            src_mem[wr_ptr_q[AW-1:0]] <= desc_src_i & AMASK;
            dst_mem[wr_ptr_q[AW-1:0]] <= desc_dst_i & AMASK;
            len_mem[wr_ptr_q[AW-1:0]] <= desc_bytes_i & LMASK;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Bytes left before each address crosses its next 4 KB page (1..4096).
    assign src_room = 13'h1000 - {1'b0, cur_src_q[11:0]};
    assign dst_room = 13'h1000 - {1'b0, cur_dst_q[11:0]};
    assign room     = src_room < dst_room ? src_room : dst_room;
    assign lim      = CW'(room) < MAX_BYTES ? CW'(room) : MAX_BYTES;
    assign chunk_w  = CW'(rem_q) < lim ? CW'(rem_q) : lim;
    assign len_w    = 8'((chunk_w >> SH) - CW'(1));
    assign rem_left = rem_q - chunk_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : LOAD;
            LOAD:    state_d = rem_q == '0 ? IDLE : CALC;
            CALC:    state_d = ISSUE;
            ISSUE:   state_d = cmd_ready_i ? WAIT : ISSUE;
            WAIT:    state_d = dma_err_i ? IDLE : !dma_done_i ? WAIT : rem_left == '0 ? IDLE : CALC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid_o  = state_q == ISSUE;
        pop          = state_q == IDLE && !empty;
        busy_o       = state_q != IDLE || !empty;
        desc_ready_o = !full;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            rem_q        <= '0;
            chunk_q      <= '0;
            cmd_src_q    <= '0;
            cmd_dst_q    <= '0;
            cmd_len_q    <= '0;
            done_pulse_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            done_err_q   <= 1'b0;
            if (pop) begin
                cur_src_q <= src_mem[rd_ptr_q[AW-1:0]];
                cur_dst_q <= dst_mem[rd_ptr_q[AW-1:0]];
                rem_q     <= len_mem[rd_ptr_q[AW-1:0]];
            end
            if (state_q == LOAD && rem_q == '0) done_pulse_q <= 1'b1;
            if (state_q == CALC) begin
                chunk_q   <= LEN_W'(chunk_w);
                cmd_src_q <= cur_src_q;
                cmd_dst_q <= cur_dst_q;
                cmd_len_q <= len_w;
            end
            // Error takes priority; the rest of the descriptor is discarded.
            if (state_q == WAIT && dma_err_i) begin
                done_pulse_q <= 1'b1;
                done_err_q   <= 1'b1;
            end else if (state_q == WAIT && dma_done_i) begin
                cur_src_q    <= cur_src_q + ADDR_W'(chunk_q);
                cur_dst_q    <= cur_dst_q + ADDR_W'(chunk_q);
                rem_q        <= rem_left;
                done_pulse_q <= rem_left == '0;
            end
        end
    end

    assign cmd_src_o    = cmd_src_q;
    assign cmd_dst_o    = cmd_dst_q;
    assign cmd_len_o    = cmd_len_q;
    assign done_pulse_o = done_pulse_q;
    assign done_err_o   = done_err_q;

`ifdef DMA_SCHED_STATS_EN
    logic [31:0] stat_bursts_q, stat_descs_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            stat_bursts_q <= '0;
            stat_descs_q  <= '0;
        end else begin
            if (cmd_valid_o && cmd_ready_i) stat_bursts_q <= stat_bursts_q + 32'd1;
            if (done_pulse_q)               stat_descs_q  <= stat_descs_q + 32'd1;
        end
    end

    assign stat_bursts_o = stat_bursts_q;
    assign stat_descs_o  = stat_descs_q;
`endif
endmodule
